// File: rtl/alu_muldiv.sv
// ALU with iterative unsigned multiply/divide: single-cycle ops land in result,
// MULT/DIV step one bit per cycle for WIDTH cycles and write {hi,lo} on completion.
// Latency: 1 cycle for single-cycle ops, WIDTH+1 cycles to done for MULT/DIV.
// Backpressure: start is ignored while busy; nothing is queued.
module alu_muldiv #(
  parameter int WIDTH   = 16,
  parameter int CMD_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CMD_LEN-1:0]       cmd,
  input  logic [WIDTH-1:0]         val1,
  input  logic [WIDTH-1:0]         val2,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  output logic [WIDTH-1:0]         result,
  output logic [WIDTH-1:0]         hi,
  output logic [WIDTH-1:0]         lo,
  output logic                     busy,
  output logic                     done,
  output logic                     div_zero
);

  localparam int SW = $clog2(WIDTH);

  localparam logic [CMD_LEN-1:0] CMD_ADD  = CMD_LEN'(0);
  localparam logic [CMD_LEN-1:0] CMD_SUB  = CMD_LEN'(1);
  localparam logic [CMD_LEN-1:0] CMD_AND  = CMD_LEN'(2);
  localparam logic [CMD_LEN-1:0] CMD_OR   = CMD_LEN'(3);
  localparam logic [CMD_LEN-1:0] CMD_NOR  = CMD_LEN'(4);
  localparam logic [CMD_LEN-1:0] CMD_XOR  = CMD_LEN'(5);
  localparam logic [CMD_LEN-1:0] CMD_CLR  = CMD_LEN'(6);
  localparam logic [CMD_LEN-1:0] CMD_SLL  = CMD_LEN'(7);
  localparam logic [CMD_LEN-1:0] CMD_MOVI = CMD_LEN'(8);
  localparam logic [CMD_LEN-1:0] CMD_SRA  = CMD_LEN'(9);
  localparam logic [CMD_LEN-1:0] CMD_SRL  = CMD_LEN'(10);
  localparam logic [CMD_LEN-1:0] CMD_MULT = CMD_LEN'(11);
  localparam logic [CMD_LEN-1:0] CMD_DIV  = CMD_LEN'(12);
  localparam logic [CMD_LEN-1:0] CMD_MFHI = CMD_LEN'(13);
  localparam logic [CMD_LEN-1:0] CMD_MFLO = CMD_LEN'(14);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } state_t;

  state_t               state_q, state_d;
  logic [SW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 dz_q, dz_d;
  // Multiplicand (MULT) or divisor (DIV), frozen at accept.
  logic [WIDTH-1:0]     opa_q, opa_d;
  // Working register: MULT = {partial sum, remaining multiplier bits};
  // DIV = {partial remainder, dividend bits shifting out / quotient bits in}.
  logic [2*WIDTH-1:0]   prod_q, prod_d;

  logic [WIDTH-1:0]     alu_res;
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       div_part;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;
  logic                 last_step;

  // Single-cycle operation result, selected from the live inputs at accept.
  always_comb begin
    alu_res = '0;
    case (cmd)
      CMD_ADD:  alu_res = val1 + val2;
      CMD_SUB:  alu_res = val1 - val2;
      CMD_AND:  alu_res = val1 & val2;
      CMD_OR:   alu_res = val1 | val2;
      CMD_NOR:  alu_res = ~(val1 | val2);
      CMD_XOR:  alu_res = val1 ^ val2;
      CMD_CLR:  alu_res = '0;
      CMD_SLL:  alu_res = val1 << shamt;
      CMD_MOVI: alu_res = val2;
      CMD_SRA:  alu_res = $unsigned($signed(val1) >>> shamt);
      CMD_SRL:  alu_res = val1 >> shamt;
      CMD_MFHI: alu_res = hi_q;
      CMD_MFLO: alu_res = lo_q;
      default:  alu_res = '0;
    endcase
  end

  // One shift-add multiply step and one restoring-divide step per cycle.
  // A zero divisor always "fits", so the quotient fills with ones and the
  // remainder ends up holding the whole dividend without special casing.
  always_comb begin
    mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{prod_q[0]}} & opa_q};
    mul_next  = {mul_sum, prod_q[WIDTH-1:1]};
    div_part  = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_ge    = div_part >= {1'b0, opa_q};
    div_next  = {(div_ge ? WIDTH'(div_part - {1'b0, opa_q}) : div_part[WIDTH-1:0]),
                 prod_q[WIDTH-2:0], div_ge};
    last_step = (cnt_q == SW'(WIDTH - 1));
  end

  // Next-state and datapath updates; every target defaults to holding.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dz_d     = dz_q;
    opa_d    = opa_q;
    prod_d   = prod_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          dz_d  = 1'b0;
          cnt_d = '0;
          if (cmd == CMD_MULT) begin
            opa_d   = val1;
            prod_d  = {{WIDTH{1'b0}}, val2};
            state_d = S_MUL;
          end else if (cmd == CMD_DIV) begin
            opa_d   = val2;
            prod_d  = {{WIDTH{1'b0}}, val1};
            state_d = S_DIV;
          end else begin
            result_d = alu_res;
            state_d  = S_DONE;
          end
        end
      end
      S_MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + SW'(1);
        if (last_step) begin
          hi_d    = mul_next[2*WIDTH-1:WIDTH];
          lo_d    = mul_next[WIDTH-1:0];
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        prod_d = div_next;
        cnt_d  = cnt_q + SW'(1);
        if (last_step) begin
          hi_d    = div_next[2*WIDTH-1:WIDTH];
          lo_d    = div_next[WIDTH-1:0];
          dz_d    = (opa_q == '0);
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state and iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Architectural and working registers; reset mid-operation discards the
  // partial product so hi/lo never see intermediate values.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dz_q     <= 1'b0;
      opa_q    <= '0;
      prod_q   <= '0;
    end else begin
      result_q <= result_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dz_q     <= dz_d;
      opa_q    <= opa_d;
      prod_q   <= prod_d;
    end
  end

  assign result   = result_q;
  assign hi       = hi_q;
  assign lo       = lo_q;
  assign div_zero = dz_q;
  assign busy     = (state_q == S_MUL) || (state_q == S_DIV);
  assign done     = (state_q == S_DONE);

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed plus random stimulus for alu_muldiv (WIDTH=16) against an
// arithmetic reference model; outputs are sampled 1 time unit after each edge.
module tb_alu_muldiv;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    cmd;
  logic [W-1:0]  val1;
  logic [W-1:0]  val2;
  logic [3:0]    shamt;
  logic [W-1:0]  result;
  logic [W-1:0]  hi;
  logic [W-1:0]  lo;
  logic          busy;
  logic          done;
  logic          div_zero;

  alu_muldiv #(.WIDTH(W), .CMD_LEN(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cmd(cmd),
    .val1(val1), .val2(val2), .shamt(shamt),
    .result(result), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference architectural state.
  logic [W-1:0] e_res, e_hi, e_lo;
  logic         e_dz;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic exp_busy, input logic exp_done);
    chk({tag, ".busy"},   32'(busy),     32'(exp_busy));
    chk({tag, ".done"},   32'(done),     32'(exp_done));
    chk({tag, ".result"}, 32'(result),   32'(e_res));
    chk({tag, ".hi"},     32'(hi),       32'(e_hi));
    chk({tag, ".lo"},     32'(lo),       32'(e_lo));
    chk({tag, ".dz"},     32'(div_zero), 32'(e_dz));
  endtask

  // Single-cycle semantics computed with plain integer arithmetic.
  function automatic logic [W-1:0] ref_single(input logic [3:0] c, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [3:0] sh,
                                               input logic [W-1:0] h, input logic [W-1:0] l);
    int ia, ib, r;
    ia = int'(a);
    ib = int'(b);
    case (c)
      4'd0:  r = (ia + ib) % 65536;
      4'd1:  r = (ia - ib + 65536) % 65536;
      4'd2:  r = ia & ib;
      4'd3:  r = ia | ib;
      4'd4:  r = 65535 - (ia | ib);
      4'd5:  r = ia ^ ib;
      4'd6:  r = 0;
      4'd7:  r = (ia * (1 << sh)) % 65536;
      4'd8:  r = ib;
      4'd9:  r = a[W-1] ? (((ia - 65536) >>> sh) & 65535) : (ia / (1 << sh));
      4'd10: r = ia / (1 << sh);
      4'd13: r = int'(h);
      4'd14: r = int'(l);
      default: r = 0;
    endcase
    return r[W-1:0];
  endfunction

  // noise: 0 = quiet while busy, 1 = random start attempts, 2 = ADD 1+1 attempts.
  task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [3:0] sh, input int noise);
    logic [31:0] p;
    start = 1'b1; cmd = c; val1 = a; val2 = b; shamt = sh;
    if (c == 4'd11 || c == 4'd12) begin
      if (c == 4'd11) begin
        p    = 32'(a) * 32'(b);
        e_hi = p[31:16];
        e_lo = p[15:0];
        e_dz = 1'b0;
      end else if (b == '0) begin
        e_lo = 16'hFFFF;
        e_hi = a;
        e_dz = 1'b1;
      end else begin
        e_lo = a / b;
        e_hi = a % b;
        e_dz = 1'b0;
      end
      tick();
      start = 1'b0;
      for (int i = 0; i < W; i++) begin
        chk({tag, ".iter"}, {30'd0, busy, done}, 32'h2);
        if (noise == 1) begin
          start = 1'($urandom); cmd = 4'($urandom);
          val1 = 16'($urandom); val2 = 16'($urandom); shamt = 4'($urandom);
        end else if (noise == 2) begin
          start = 1'b1; cmd = 4'd0; val1 = 16'd1; val2 = 16'd1;
        end
        tick();
      end
      start = 1'b0;
      chk_state({tag, ".end"}, 1'b0, 1'b1);
    end else begin
      e_res = ref_single(c, a, b, sh, e_hi, e_lo);
      e_dz  = 1'b0;
      tick();
      start = 1'b0;
      chk_state({tag, ".end"}, 1'b0, 1'b1);
    end
  endtask

  task automatic zero_model();
    e_res = '0; e_hi = '0; e_lo = '0; e_dz = 1'b0;
  endtask

  initial begin
    logic [3:0]   rc;
    logic [W-1:0] ra, rb;

    // Reset, with start held high to show reset takes priority.
    rst = 1'b1; start = 1'b1; cmd = 4'd11; val1 = 16'd5; val2 = 16'd6; shamt = '0;
    zero_model();
    tick(); tick();
    chk_state("reset", 1'b0, 1'b0);
    rst = 1'b0; start = 1'b0;
    tick();
    chk_state("post_reset_idle", 1'b0, 1'b0);

    // Shifts and wraparound add.
    run_op("sra", 4'd9, 16'h8000, 16'h0000, 4'd3, 0);
    chk("sra_const", 32'(result), 32'hF000);
    tick();
    chk("idle_after_done", 32'(done), 32'd0);
    run_op("srl", 4'd10, 16'h8000, 16'h0000, 4'd3, 0);
    chk("srl_const", 32'(result), 32'h1000);
    run_op("sll", 4'd7, 16'h0001, 16'h0000, 4'd15, 0);
    chk("sll_const", 32'(result), 32'h8000);
    run_op("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 4'd0, 0);
    chk("add_const", 32'(result), 32'h0000);
    tick();

    // Full-scale multiply with busy/done timing.
    run_op("mult_max", 4'd11, 16'hFFFF, 16'hFFFF, 4'd0, 0);
    chk("mult_max_hi", 32'(hi), 32'hFFFE);
    chk("mult_max_lo", 32'(lo), 32'h0001);
    tick();

    // Division, normal then by zero.
    run_op("div_100_7", 4'd12, 16'd100, 16'd7, 4'd0, 0);
    chk("div_q", 32'(lo), 32'd14);
    chk("div_r", 32'(hi), 32'd2);
    run_op("div_zero", 4'd12, 16'h1234, 16'h0000, 4'd0, 0);
    chk("dz_lo", 32'(lo), 32'hFFFF);
    chk("dz_hi", 32'(hi), 32'h1234);
    chk("dz_flag", 32'(div_zero), 32'd1);
    tick();

    // Start attempts while busy are ignored.
    run_op("mult_7_9", 4'd11, 16'd7, 16'd9, 4'd0, 2);
    chk("mult_7_9_lo", 32'(lo), 32'd63);
    chk("mult_7_9_hi", 32'(hi), 32'd0);
    tick();
    chk("single_done_pulse", 32'(done), 32'd0);

    // Reset in the 8th busy cycle aborts the multiply.
    start = 1'b1; cmd = 4'd11; val1 = 16'h1234; val2 = 16'h5678;
    tick();
    start = 1'b0;
    repeat (7) tick();
    chk("mid_mult_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    zero_model();
    chk_state("abort", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", {30'd0, busy, done}, 32'h0);
    end

    // Recovery multiply, then MFLO back-to-back in its done cycle.
    run_op("mult_3_5", 4'd11, 16'd3, 16'd5, 4'd0, 0);
    chk("mult_3_5_lo", 32'(lo), 32'd15);
    run_op("mflo_b2b", 4'd14, 16'hAAAA, 16'h5555, 4'd0, 0);
    chk("mflo_const", 32'(result), 32'd15);
    tick();

    // Random traffic, including back-to-back issue and busy-time noise.
    for (int n = 0; n < 60; n++) begin
      rc = 4'($urandom_range(0, 15));
      ra = 16'($urandom);
      rb = ($urandom_range(0, 5) == 0) ? 16'd0 : 16'($urandom);
      run_op("rand", rc, ra, rb, 4'($urandom), int'($urandom_range(0, 1)));
      if ($urandom_range(0, 2) == 0) begin
        tick();
        chk_state("rand_idle", 1'b0, 1'b0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
